// File: rtl/uart_pkg.sv
// Shared UART receive types and constants.
// Frame words carry data plus four error tags.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // data is sized for the widest frame; unused MSBs stay zero
  typedef struct packed {
    logic                     ovf;
    logic                     brk;
    logic                     ferr;
    logic                     perr;
    logic [MAX_DATA_BITS-1:0] data;
  } uart_rx_word_t;

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic synchronous FIFO with a registered head word.
// Push and pop may occur together; a pop frees space for the push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      count;
  logic [AW:0]      cnt_nxt;
  logic             do_push;
  logic             do_pop;
  logic             bypass;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rd_nxt  = rd_ptr + AW'(do_pop);
    cnt_nxt = count + (AW+1)'(do_push)
            - (AW+1)'(do_pop);
    // new word becomes head straight away when nothing else is left
    bypass  = do_push
            & (count == (AW+1)'(do_pop));
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q      <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      if (cnt_nxt != '0)
        q <= bypass ? din : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority vote, break detect
// and a tagged receive FIFO toward a valid/ready consumer.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 baud_os_strobe,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 break_detect,
  output logic                 overflow_error,
  output logic                 valid,
  input  logic                 ready
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int FW = $bits(uart_rx_word_t);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(OVERSAMPLE - 1);
  localparam logic ODD = (PARITY == PAR_ODD);

  rx_state_t            state;
  logic [1:0]           prev;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic                 sidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 perr;
  logic                 ferr;
  logic                 zeros;
  logic                 ovf_pending;

  logic                 tick;
  logic                 ev;
  logic                 ms;
  logic                 last_stop;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 full;
  logic                 empty;
  uart_rx_word_t        word;
  uart_rx_word_t        head;
  logic                 unused_head;

  always_comb begin
    tick      = clken & baud_os_strobe;
    ms        = maj3(prev[1], prev[0], rxd);
    ev        = tick & (cnt == '0);
    last_stop = (sidx == 1'(STOP_BITS - 1));
    push      = ev & (state == RX_STOP) & last_stop;
    pop       = ~empty & ready & clken;
    accept    = ~full | pop;
    word      = '0;
    word.data[DATA_BITS-1:0] = shreg;
    word.perr = perr;
    word.ferr = ferr | ~ms;
    word.brk  = zeros & ~ms;
    word.ovf  = ovf_pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RX_IDLE;
      prev        <= 2'b11;
      cnt         <= '0;
      idx         <= '0;
      sidx        <= 1'b0;
      shreg       <= '0;
      par_acc     <= 1'b0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      zeros       <= 1'b0;
      ovf_pending <= 1'b0;
    end else if (tick) begin
      prev <= {prev[0], rxd};
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (push) ovf_pending <= ~accept;
      unique case (state)
        RX_IDLE: begin
          if (!ms) begin
            cnt   <= HALF_M1;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (ev) begin
            if (ms) begin
              state <= RX_IDLE;
            end else begin
              cnt     <= FULL_M1;
              idx     <= '0;
              par_acc <= 1'b0;
              perr    <= 1'b0;
              ferr    <= 1'b0;
              zeros   <= 1'b1;
              state   <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (ev) begin
            shreg   <= {ms, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ ms;
            zeros   <= zeros & ~ms;
            cnt     <= FULL_M1;
            idx     <= idx + 4'd1;
            if (idx == 4'(DATA_BITS - 1)) begin
              sidx  <= 1'b0;
              state <= (PARITY != PAR_NONE)
                     ? RX_PAR : RX_STOP;
            end
          end
        end
        RX_PAR: begin
          if (ev) begin
            perr  <= (par_acc ^ ms) != ODD;
            zeros <= zeros & ~ms;
            cnt   <= FULL_M1;
            state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (ev) begin
            ferr  <= ferr | ~ms;
            zeros <= zeros & ~ms;
            cnt   <= FULL_M1;
            if (last_stop)
              // a low stop bit may be a break; wait for idle
              state <= ms ? RX_IDLE : RX_WAIT_HIGH;
            else
              sidx <= 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (ms) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .q     (head),
    .full  (full),
    .empty (empty)
  );

  assign valid          = ~empty;
  assign data           = head.data[DATA_BITS-1:0];
  assign parity_error   = head.perr;
  assign frame_error    = head.ferr;
  assign break_detect   = head.brk;
  assign overflow_error = head.ovf;
  assign unused_head    = ^head.data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are built from bits,
// expectations come from frame-level rules, a monitor pops words.
module tb_uart_rx_fifo;

  localparam int DB    = 8;
  localparam int PAR   = 1;
  localparam int SB    = 2;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
    logic          bd;
    logic          ov;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clken = 1'b1;
  logic          baud_os_strobe = 1'b0;
  logic          rxd = 1'b1;
  logic          ready = 1'b0;
  logic [DB-1:0] data;
  logic          parity_error;
  logic          frame_error;
  logic          break_detect;
  logic          overflow_error;
  logic          valid;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nstrobe = 0;
  int   div = 0;
  bit   ready_en = 1'b0;
  bit   ovf_pend = 1'b0;

  uart_rx_fifo #(
    .DATA_BITS  (DB),
    .PARITY     (PAR),
    .STOP_BITS  (SB),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clken          (clken),
    .baud_os_strobe (baud_os_strobe),
    .rxd            (rxd),
    .data           (data),
    .parity_error   (parity_error),
    .frame_error    (frame_error),
    .break_detect   (break_detect),
    .overflow_error (overflow_error),
    .valid          (valid),
    .ready          (ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div = (div == 2) ? 0 : div + 1;
    baud_os_strobe = (div == 0);
  end

  always @(posedge clk)
    if (baud_os_strobe && clken) nstrobe <= nstrobe + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_strobes(int n);
    int t;
    t = nstrobe + n;
    while (nstrobe < t) @(negedge clk);
  endtask

  function automatic exp_t model(logic [DB-1:0] d,
                                 logic pb,
                                 logic [SB-1:0] st);
    exp_t e;
    e.d  = d;
    e.pe = (PAR != 0) && ((^d ^ pb) != (PAR == 2));
    e.fe = (st != '1);
    e.bd = (d == 0) && (PAR == 0 || !pb) && (st == 0);
    e.ov = 1'b0;
    return e;
  endfunction

  task automatic expect_word(exp_t e);
    if (exp_q.size() >= DEPTH) begin
      ovf_pend = 1'b1;
    end else begin
      e.ov = ovf_pend;
      ovf_pend = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_bits(logic [15:0] bits, int n, int glitch);
    for (int k = 0; k < n; k++) begin
      rxd = bits[k];
      if (k == glitch) begin
        wait_strobes(8);
        rxd = ~bits[k];
        wait_strobes(1);
        rxd = bits[k];
        wait_strobes(OS - 9);
      end else begin
        wait_strobes(OS);
      end
    end
  endtask

  function automatic logic [15:0] build(logic [DB-1:0] d,
                                        logic pb,
                                        logic [SB-1:0] st);
    logic [15:0] b;
    int n;
    b = '0;
    n = 1;
    for (int i = 0; i < DB; i++) begin
      b[n] = d[i];
      n++;
    end
    if (PAR != 0) begin
      b[n] = pb;
      n++;
    end
    for (int i = 0; i < SB; i++) begin
      b[n] = st[i];
      n++;
    end
    return b;
  endfunction

  task automatic send_frame(logic [DB-1:0] d, logic pb,
                            logic [SB-1:0] st, int glitch);
    expect_word(model(d, pb, st));
    drive_bits(build(d, pb, st), NBITS, glitch);
    rxd = 1'b1;
    wait_strobes(4);
  endtask

  function automatic logic good_par(logic [DB-1:0] d);
    return (^d) ^ (PAR == 2);
  endfunction

  task automatic send_good(logic [DB-1:0] d, int glitch);
    send_frame(d, good_par(d), '1, glitch);
  endtask

  task automatic latency_chk();
    int tgt;
    int g;
    tgt = nstrobe + OS / 2 + 2 + OS * (NBITS - 1);
    g = 0;
    #1;
    while (!(nstrobe == tgt - 1 && baud_os_strobe)
           && g < 20000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("valid_before_push", valid, 0);
    @(negedge clk);
    #1;
    chk("valid_after_push", valid, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      ready = ready_en ? ($urandom_range(0, 9) < 7) : 1'b0;
      if (!rst && valid && ready && clken) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none",
                   data);
        end else begin
          e = exp_q.pop_front();
          chk("word",
              {data, parity_error, frame_error,
               break_detect, overflow_error}, e);
        end
      end
    end
  end

  initial begin : main
    logic [DB-1:0] d;
    logic          pb;
    logic [SB-1:0] st;
    int            gl;

    repeat (5) @(negedge clk);
    #1;
    chk("rst_data", data, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_brk", break_detect, 0);
    chk("rst_ovf", overflow_error, 0);
    chk("rst_valid", valid, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_strobes(4);

    fork
      send_good(8'hA5, -1);
      latency_chk();
    join
    ready_en = 1'b1;
    drain();

    send_frame(8'h41, 1'b1, '1, -1);
    send_frame(8'h41, 1'b0, '1, -1);
    send_frame(8'h41, 1'b0, 2'b01, -1);
    drain();

    rxd = 1'b0;
    wait_strobes(4);
    rxd = 1'b1;
    wait_strobes(24);
    chk("false_start", valid, 0);
    send_good(8'h96, 3);
    send_good(8'h69, 0);
    send_good(8'hF0, NBITS - 1);
    drain();

    expect_word(model('0, 1'b0, '0));
    rxd = 1'b0;
    wait_strobes(2 * NBITS * OS);
    rxd = 1'b1;
    wait_strobes(8);
    send_good(8'h55, -1);
    drain();

    ready_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 6; i++) send_good(DB'(i), -1);
    #1;
    chk("full_head", data, 1);
    chk("full_valid", valid, 1);
    ready_en = 1'b1;
    drain();
    send_good(8'h07, -1);
    drain();

    ready_en = 1'b0;
    send_good(8'h11, -1);
    drive_bits(build(8'hFF, 1'b0, '1), 4, -1);
    rxd = 1'b1;
    wait_strobes(8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ovf_pend = 1'b0;
    #1;
    chk("flush_valid", valid, 0);
    wait_strobes(2 * OS);
    ready_en = 1'b1;
    send_good(8'h3C, -1);
    drain();

    fork
      send_good(8'hC3, -1);
      begin
        wait_strobes(OS * 5 + 3);
        clken = 1'b0;
        repeat (50) @(negedge clk);
        clken = 1'b1;
      end
    join
    drain();

    for (int n = 0; n < 25; n++) begin
      d  = DB'($urandom);
      pb = good_par(d) ^ ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 5) == 0) ? SB'($urandom) : '1;
      gl = ($urandom_range(0, 3) == 0)
         ? $urandom_range(0, NBITS - 1) : -1;
      send_frame(d, pb, st, gl);
      wait_strobes($urandom_range(0, 10));
    end
    drain();

    repeat (50) @(negedge clk);
    #1;
    chk("end_valid", valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
